// File: rtl/muldiv_unit.sv
// ============================================================================
//  Module   : muldiv_unit
//  Brief    : Iterative RV32M multiply/divide unit (shift-add / restoring).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            kill,
    input  logic [4:0]      alufn,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [4:0] c_last_iter = 5'd31;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          r_state;
    logic [4:0]      r_count;
    logic [2:0]      r_f3;
    logic            r_sa;
    logic            r_sb;
    logic            r_bzero;
    logic [XLEN-1:0] r_hi;      // product high word / partial remainder
    logic [XLEN-1:0] r_lo;      // multiplier then product low word / quotient
    logic [XLEN-1:0] r_opb;     // multiplicand / divisor magnitude
    logic            r_busy;
    logic            r_done;
    logic [XLEN-1:0] r_result;

    logic            w_accept;
    logic            w_in_sa;
    logic            w_in_sb;
    logic [XLEN-1:0] w_mag_a;
    logic [XLEN-1:0] w_mag_b;
    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_shift;
    logic [XLEN+1:0] w_diff;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0] w_quot;
    logic [XLEN-1:0] w_rem;
    logic [XLEN-1:0] w_fix;
    logic            w_unused;

    assign w_accept = start && alufn[4];

    always_comb begin
        w_in_sa = 1'b0;
        w_in_sb = 1'b0;
        case (alufn[2:0])
            3'b001, 3'b100, 3'b110: begin
                w_in_sa = a[XLEN-1];
                w_in_sb = b[XLEN-1];
            end
            3'b010:  w_in_sa = a[XLEN-1];
            default: ;
        endcase
    end

    assign w_mag_a = w_in_sa ? -a : a;
    assign w_mag_b = w_in_sb ? -b : b;

    // One shift-add step: add multiplicand on multiplier LSB, shift the pair right.
    assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : {(XLEN+1){1'b0}});

    // One restoring step on the 33-bit partial remainder; sign bit of w_diff says "did not fit".
    assign w_shift = {r_hi, r_lo[XLEN-1]};
    assign w_diff  = {1'b0, w_shift} - {2'b00, r_opb};

    assign w_prod   = {r_hi, r_lo};
    assign w_prod_s = (r_sa ^ r_sb) ? -w_prod : w_prod;
    assign w_quot   = (r_sa ^ r_sb) ? -r_lo : r_lo;
    assign w_rem    = r_sa ? -r_hi : r_hi;

    // Overflow and REM-by-zero fall out of the magnitude arithmetic; only DIV by zero needs forcing.
    always_comb begin
        w_fix = w_rem;
        case (r_f3)
            3'b000:                 w_fix = w_prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_fix = w_prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_fix = r_bzero ? {XLEN{1'b1}} : w_quot;
            default:                w_fix = w_rem;
        endcase
    end

    assign w_unused = ^{w_diff[XLEN], w_prod_s[XLEN-1:0], alufn[3]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_count  <= 5'd0;
            r_f3     <= 3'd0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_bzero  <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opb    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else if (kill) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_state <= S_CALC;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_count <= c_last_iter;
                        r_f3    <= alufn[2:0];
                        r_sa    <= w_in_sa;
                        r_sb    <= w_in_sb;
                        r_bzero <= (b == '0);
                        r_hi    <= '0;
                        r_lo    <= w_mag_a;
                        r_opb   <= w_mag_b;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                end
                S_CALC: begin
                    if (r_f3[2]) begin
                        if (!w_diff[XLEN+1]) begin
                            r_hi <= w_diff[XLEN-1:0];
                            r_lo <= {r_lo[XLEN-2:0], 1'b1};
                        end else begin
                            r_hi <= w_shift[XLEN-1:0];
                            r_lo <= {r_lo[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        r_hi <= w_sum[XLEN:1];
                        r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
                    end
                    r_count <= r_count - 5'd1;
                    if (r_count == 5'd0) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_result <= w_fix;
                    r_state  <= S_DONE;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
//  Module   : tb_muldiv_unit
//  Brief    : Self-checking bench for muldiv_unit (vector table + random ops).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        kill;
    logic [4:0]  alufn;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .kill   (kill),
        .alufn  (alufn),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    // Reference: plain 64-bit / signed integer arithmetic with the RV32M special cases.
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] sx, zx, sy, zy, p;
        sx = {{32{x[31]}}, x};
        zx = {32'd0, x};
        sy = {{32{y[31]}}, y};
        zy = {32'd0, y};
        p  = 64'd0;
        case (f3)
            3'd0: begin p = zx * zy; return p[31:0];  end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * zy; return p[63:32]; end
            3'd3: begin p = zx * zy; return p[63:32]; end
            3'd4: begin
                if (y == 32'd0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
                return $signed(x) / $signed(y);
            end
            3'd5: return (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 32'd0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
                return $signed(x) % $signed(y);
            end
            default: return (y == 32'd0) ? x : x % y;
        endcase
    endfunction

    // Called just after a rising edge; drives the request and counts cycles to done.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] xa, input logic [31:0] xb,
                          input bit disturb, output logic [31:0] res, output int lat);
        alufn = {2'b10, f3};
        a     = xa;
        b     = xb;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        alufn = 5'($urandom);
        a     = $urandom;
        b     = $urandom;
        lat   = 1;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        while (!done && lat < 60) begin
            if (disturb && lat == 5) begin
                start = 1'b1;
                alufn = {2'b10, 3'(~f3)};
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        res   = result;
        check("busy_at_done", {31'd0, busy}, 32'd0);
    endtask

    task automatic do_op(input string name, input logic [2:0] f3, input logic [31:0] xa,
                         input logic [31:0] xb, input logic [31:0] exp);
        logic [31:0] res;
        int          lat;
        run_op(f3, xa, xb, 1'b0, res, lat);
        check(name, res, exp);
        check({name, "_latency"}, lat, 34);
        @(posedge clk); #1;
    endtask

    task automatic wait_no_done(input int n, input string name);
        bit seen = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        check(name, {31'd0, seen}, 32'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'd0;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] res1, res2, last;
        int          lat1, lat2;
        bit          bad;

        vecs[0]  = '{"mul_7_m3",      3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1]  = '{"mulhu_max",     3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[2]  = '{"mulh_min",      3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
        vecs[3]  = '{"mulhsu_m1",     3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[4]  = '{"div_m7_2",      3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
        vecs[5]  = '{"rem_m7_2",      3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
        vecs[6]  = '{"divu_100_7",    3'd5, 32'd100,        32'd7,         32'd14};
        vecs[7]  = '{"remu_100_7",    3'd7, 32'd100,        32'd7,         32'd2};
        vecs[8]  = '{"divu_by_zero",  3'd5, 32'h1234,       32'd0,         32'hFFFF_FFFF};
        vecs[9]  = '{"remu_by_zero",  3'd7, 32'h1234,       32'd0,         32'h1234};
        vecs[10] = '{"div_overflow",  3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
        vecs[11] = '{"rem_overflow",  3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0};
        vecs[12] = '{"div_neg_by_0",  3'd4, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF};
        vecs[13] = '{"rem_neg_by_0",  3'd6, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9};

        rst_n = 1'b0;
        start = 1'b0;
        kill  = 1'b0;
        alufn = 5'd0;
        a     = 32'd0;
        b     = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        check("reset_busy",   {31'd0, busy}, 32'd0);
        check("reset_done",   {31'd0, done}, 32'd0);
        check("reset_result", result,        32'd0);

        bad = 1'b0;
        repeat (100) begin
            @(posedge clk); #1;
            if (busy || done || result != 32'd0) bad = 1'b1;
        end
        check("idle_100_cycles", {31'd0, bad}, 32'd0);

        // Non-M function code with start must not be accepted.
        alufn = 5'b00101;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("non_m_ignored_busy", {31'd0, busy}, 32'd0);
        wait_no_done(40, "non_m_no_done");

        for (int i = 0; i < 14; i++) begin
            do_op(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp);
        end
        last = 32'hFFFF_FFF9;

        // Kill in cycle 10 of a DIV.
        alufn = 5'b10100;
        a     = 32'd100;
        b     = 32'd7;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill_busy_low", {31'd0, busy}, 32'd0);
        check("kill_done_low", {31'd0, done}, 32'd0);
        wait_no_done(40, "kill_no_done");
        check("kill_result_held", result, last);

        // Start together with kill is not accepted.
        alufn = 5'b10000;
        a     = 32'd3;
        b     = 32'd5;
        start = 1'b1;
        kill  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        kill  = 1'b0;
        check("start_kill_busy", {31'd0, busy}, 32'd0);
        wait_no_done(40, "start_kill_no_done");

        // Asynchronous reset in cycle 20 of a MUL.
        alufn = 5'b10000;
        a     = 32'd7;
        b     = 32'd3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) begin @(posedge clk); #1; end
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_busy",   {31'd0, busy}, 32'd0);
        check("async_reset_done",   {31'd0, done}, 32'd0);
        check("async_reset_result", result,        32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        wait_no_done(40, "reset_no_done");

        // Back-to-back: second request raised in the first op's DONE cycle.
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, res1, lat1);
        run_op(3'd5, 32'd100, 32'd7, 1'b0, res2, lat2);
        check("b2b_first_result",  res1, 32'hFFFF_FFFE);
        check("b2b_first_latency", lat1, 34);
        check("b2b_second_result", res2, 32'd14);
        check("b2b_done_to_done",  lat2, 34);
        @(posedge clk); #1;

        // Start pulsed during CALC is ignored.
        run_op(3'd7, 32'd100, 32'd7, 1'b1, res1, lat1);
        check("calc_start_result",  res1, 32'd2);
        check("calc_start_latency", lat1, 34);
        wait_no_done(40, "calc_start_no_extra_done");

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f3;
            logic [31:0] ra, rb;
            f3 = 3'($urandom_range(0, 7));
            ra = pick_operand();
            rb = pick_operand();
            do_op($sformatf("rand%0d_f%0d_%h_%h", i, f3, ra, rb), f3, ra, rb, model(f3, ra, rb));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide execution unit for the RV32M extension in the pipelined core. It sits directly downstream of the ALU control decoder and consumes the 5-bit `alufn` code whenever bit 4 is set (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU). It computes the result over a fixed number of cycles using a radix-2 shift-add multiplier and a restoring divider. While the operation runs it asserts `busy` so the hazard unit stalls the pipeline.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- clk  in  1  core clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when state is IDLE or DONE.
- kill  in  1  pipeline flush; aborts any operation in progress.
- alufn  in  5  ALU function code; bit 4 = M-op, bits [2:0] = funct3 (000 MUL … 111 REMU).
- a  in  32  rs1 operand (multiplicand or dividend).
- b  in  32  rs2 operand (multiplier or divisor).
- busy  out  1  high while an accepted op is in CALC or FIX.
- done  out  1  one-cycle pulse; `result` is valid in this cycle.
- result  out  32  registered result; holds until the next acceptance.

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- Acceptance: `start`=1, `alufn[4]`=1 and `kill`=0 while in IDLE or DONE.
  - On acceptance, latch funct3, the operand signs and the operand magnitudes, then go to CALC with count=31.
  - `start` with `alufn[4]`=0 is ignored.
  - `start` in CALC or FIX is ignored.
- Signedness by op:
  - MULH, DIV and REM treat both operands as signed.
  - MULHSU treats `a` as signed and `b` as unsigned.
  - MUL, MULHU, DIVU and REMU are unsigned. MUL's low word is sign-independent.
- CALC runs 32 iterations, one per cycle, on magnitudes.
  - Multiply: 64-bit shift-add accumulator.
  - Divide: restoring; 33-bit partial remainder, 32-bit quotient.
  - The counter decrements each cycle; at count=0 go to FIX.
- FIX (1 cycle) performs sign correction and selection, then writes `result` and goes to DONE.
  - MUL: low 32 bits of the product.
  - MULH/MULHSU/MULHU: high 32 bits. The 64-bit product is negated first if the operand signs differ under the op's signedness.
  - DIV: quotient, negated if the signs differ. REM: remainder, taking the sign of the dividend.
  - Divide by zero (b=0): DIV/DIVU give 0xFFFFFFFF; REM/REMU give the original `a`.
  - Signed overflow (DIV/REM with a=0x80000000, b=0xFFFFFFFF): DIV gives 0x80000000, REM gives 0.
  - Both special cases still take the full latency.
- DONE lasts one cycle with `done`=1, then IDLE. A new acceptance in DONE goes straight to CALC.
- `kill`=1 in any state forces IDLE on the next edge.
  - `done` is not pulsed and `result` is not updated.
  - `kill` takes priority over a simultaneous `start`.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0x00000000, counter 0, datapath registers 0.
- Reset is asynchronous. Asserting it mid-operation returns the unit to IDLE immediately, with no `done`.
- Latency is fixed for every op. Cycle 0 is the cycle in which `start` is sampled high.
  - Cycles 1–32: CALC, `busy`=1.
  - Cycle 33: FIX, `busy`=1.
  - Cycle 34: DONE, `done`=1, `busy`=0, `result` valid.
- Back-to-back: with `start` high in cycle 34, the next op's `done` is in cycle 68.
- `result` is stable from cycle 34 until the cycle after the next acceptance.
- Operands only need to be valid in cycle 0; later changes to `a`, `b` or `alufn` have no effect.
- `busy` is registered and derived from state only. It has no combinational path from `start`.

## Test plan
- Reset then idle: no `start` for 100 cycles → `busy`=0, `done`=0, `result`=0 throughout.
- MUL a=7, b=0xFFFFFFFD → done in cycle 34, result 0xFFFFFFEB. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULH 0x80000000×0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (−7), b=2 → 0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- Corner cases:
  - DIVU 0x1234/0 → 0xFFFFFFFF. REMU 0x1234/0 → 0x1234.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM with the same operands → 0.
  - Latency is 34 in all of these cases.
- `kill` pulsed in cycle 10 of a DIV → IDLE in cycle 11, no `done`, `result` unchanged. A `start` with simultaneous `kill` is not accepted.
- Asynchronous reset asserted in cycle 20 of a MUL → `busy`=0 immediately, no `done`. Back-to-back ops with `start` held in the DONE cycle → second `done` 34 cycles after the first. `start` during CALC is ignored.
